rst_sequencer: RTL and testbench
================================

# rst_sequencer

Generates the ordered, stretched reset releases that the synchronizer flops in each quadcopter sub-domain consume. It merges three reset sources: the board reset, a debounced pushbutton, and a soft-reset handshake from the command processor. It releases active-low resets in a fixed order: sensor interface, then flight controller, then ESC/motor drive. Any new reset event re-asserts all outputs together.

## Interface
- DB_CYCLES, 16: consecutive identical synchronized PB_n samples required to change debounced button state (≥2).
- STRETCH, 64: cycles all resets are held after the last reset source clears (≥1).
- STAGE_DLY, 8: cycles between successive stage releases (≥1).
- clk  input  1  system clock; all flops posedge.
- RST_n  input  1  board reset, asynchronous, active-low.
- PB_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
- soft_req  input  1  soft-reset request level from command processor.
- soft_ack  output  1  one-cycle pulse: soft request accepted.
- rst_sens_n  output  1  sensor-interface reset, active-low.
- rst_flt_n  output  1  flight-controller reset, active-low.
- rst_esc_n  output  1  ESC/motor reset, active-low.
- rst_done  output  1  high when all stages are released.

## Operation
- RST_n low: all flops clear asynchronously.
  - rst_*_n = 0, rst_done = 0, soft_ack = 0, state = HOLD, counters = 0, debounced button = released (1), soft arm flag = 0.
  - RST_n is internally retimed through a two-flop chain. Assertion is asynchronous; the state machine sees deassertion on the 2nd posedge after RST_n rises.
- PB_n path:
  - Two-flop synchronizer, then debounce counter.
  - The counter increments while the synchronized value differs from the debounced value, and clears when they match.
  - When the counter reaches DB_CYCLES, the debounced value takes the synchronized value and the counter clears.
- Soft handshake:
  - The arm flag sets on any cycle soft_req is sampled 0.
  - A request is accepted when soft_req = 1 and arm = 1. Acceptance clears arm and pulses soft_ack for exactly one cycle.
  - A held-high soft_req is never accepted twice.
- Reset event: accepted soft request, or debounced button low. A reset event is valid in any state.
- States:
  - HOLD: all outputs low, counter counts 0..STRETCH-1. A reset event clears the counter and stays in HOLD. At count STRETCH-1 → SENS.
  - SENS: rst_sens_n = 1, counter counts STAGE_DLY → FLT.
  - FLT: rst_sens_n = rst_flt_n = 1, counter counts STAGE_DLY → ESC.
  - ESC (terminal run state): all three outputs = 1, rst_done = 1.
  - Reset event in SENS/FLT/ESC → HOLD, counter = 0. All outputs go low on the same edge, with no partial-stage glitch.
- Outputs are registered decodes of state only, so they are glitch-free.
- Button held low keeps the block in HOLD indefinitely. Button release (debounced) is not itself an event; stretch timing starts from the last event cycle.
- Button and soft request in the same cycle: both honored, soft_ack still pulses, single restart.

## Timing
- T0 = first posedge with internal reset deasserted.
  - rst_sens_n rises at T0+STRETCH.
  - rst_flt_n rises at T0+STRETCH+STAGE_DLY.
  - rst_esc_n and rst_done rise at T0+STRETCH+2·STAGE_DLY.
- Soft request sampled high (armed) at edge E: soft_ack high and all rst_*_n low after edge E+1. Release timeline restarts with T0 = E+1.
- PB_n falling clean: outputs low DB_CYCLES+3 edges later (2 sync + DB_CYCLES filter + 1 state register).
- PB_n pulses or bounces shorter than DB_CYCLES synchronized cycles: no effect.
- RST_n low mid-sequence: outputs low immediately (combinational path from async clear only), no clock needed.

## Test plan
- Power-up: RST_n low 5 cycles then high, defaults → rst_sens_n rises at T0+64, rst_flt_n at T0+72, rst_esc_n and rst_done at T0+80. soft_ack stays 0.
- Soft reset: in ESC, raise soft_req and hold 20 cycles → exactly one soft_ack pulse, all outputs low the next edge, re-release at +64/+72/+80. Drop soft_req for 1 cycle then raise → second ack.
- Soft_req high through RST_n release → no ack until soft_req seen low.
- Bounce: in ESC, PB_n toggling with 10-cycle lows → no reset. PB_n low 40 cycles → outputs low at +19 edges, stay low while held, release sequence starts 64 cycles after debounced release.
- RST_n asserted mid-FLT without clock → all outputs 0 and rst_done 0 immediately.
- Simultaneous: armed soft_req and debounced press on same edge → one soft_ack, single restart, timing per soft path.

Source files
------------

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rst_sequencer
//  Purpose  : Merges board reset, a debounced pushbutton and a soft-reset
//             handshake into ordered, stretched active-low reset releases:
//             sensor interface, then flight controller, then ESC/motor drive.
//             Any new reset event re-asserts every output on the same edge.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, all flops on posedge
//    RST_n       in   board reset, asynchronous assert, active-low
//    PB_n        in   raw pushbutton, active-low, asynchronous and bouncy
//    soft_req    in   soft-reset request level from the command processor
//    soft_ack    out  one-cycle pulse when a soft request is accepted
//    rst_sens_n  out  sensor-interface reset, active-low
//    rst_flt_n   out  flight-controller reset, active-low
//    rst_esc_n   out  ESC/motor reset, active-low
//    rst_done    out  high once all three stages are released
// ============================================================================
module rst_sequencer #(
    parameter int DB_CYCLES = 16,
    parameter int STRETCH   = 64,
    parameter int STAGE_DLY = 8
) (
    input  logic clk,
    input  logic RST_n,
    input  logic PB_n,
    input  logic soft_req,
    output logic soft_ack,
    output logic rst_sens_n,
    output logic rst_flt_n,
    output logic rst_esc_n,
    output logic rst_done
);

    localparam int CNT_MAX = (STRETCH > STAGE_DLY) ? STRETCH : STAGE_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = $clog2(DB_CYCLES + 1);

    localparam logic [CW-1:0] C_STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] C_STAGE_LAST   = CW'(STAGE_DLY - 1);
    localparam logic [DW-1:0] C_DB_LAST      = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SENS = 2'd1,
        FLT  = 2'd2,
        ESC  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Board reset retiming: asserts asynchronously, releases after two
    // clock edges so every downstream flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_int_n;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_int_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Pushbutton: two-flop synchronizer followed by a run-length filter.
    // The synchronizer flops reset to the released level so a reset
    // release never looks like a press.
    // ------------------------------------------------------------------
    logic          r_pb_meta;
    logic          r_pb_sync;
    logic          r_pb_deb;
    logic [DW-1:0] r_db_cnt;

    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_pb_meta <= 1'b1;
            r_pb_sync <= 1'b1;
            r_pb_deb  <= 1'b1;
            r_db_cnt  <= '0;
        end else begin
            r_pb_meta <= PB_n;
            r_pb_sync <= r_pb_meta;
            if (r_pb_sync != r_pb_deb) begin
                // DB_CYCLES-th consecutive disagreeing sample flips the state
                if (r_db_cnt == C_DB_LAST) begin
                    r_pb_deb <= r_pb_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Soft-reset handshake. The arm flag is set from the raw request so a
    // request that is already high when reset releases is never accepted
    // until it has been observed low; acceptance uses the registered copy.
    // ------------------------------------------------------------------
    logic r_req;
    logic r_arm;
    logic w_accept;
    logic w_event;

    assign w_accept = r_req & r_arm;
    assign w_event  = w_accept | ~r_pb_deb;

    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_req    <= 1'b0;
            r_arm    <= 1'b0;
            soft_ack <= 1'b0;
        end else begin
            r_req    <= soft_req;
            soft_ack <= w_accept;
            if (!soft_req) begin
                r_arm <= 1'b1;
            end else if (w_accept) begin
                r_arm <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Release sequencer. Outputs are updated together with the state they
    // decode, so a reset event drops all stages on one edge.
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            rst_sens_n <= 1'b0;
            rst_flt_n  <= 1'b0;
            rst_esc_n  <= 1'b0;
            rst_done   <= 1'b0;
        end else if (w_event) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            rst_sens_n <= 1'b0;
            rst_flt_n  <= 1'b0;
            rst_esc_n  <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == C_STRETCH_LAST) begin
                        r_state    <= SENS;
                        r_cnt      <= '0;
                        rst_sens_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SENS: begin
                    if (r_cnt == C_STAGE_LAST) begin
                        r_state   <= FLT;
                        r_cnt     <= '0;
                        rst_flt_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FLT: begin
                    if (r_cnt == C_STAGE_LAST) begin
                        r_state   <= ESC;
                        r_cnt     <= '0;
                        rst_esc_n <= 1'b1;
                        rst_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ESC: begin
                    r_state <= ESC;
                end
                default: begin
                    r_state    <= HOLD;
                    r_cnt      <= '0;
                    rst_sens_n <= 1'b0;
                    rst_flt_n  <= 1'b0;
                    rst_esc_n  <= 1'b0;
                    rst_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_sequencer
//  Purpose  : Self-checking bench for rst_sequencer. A timeline model tracks
//             the cycle of the most recent reset event and derives each
//             release from the elapsed cycle count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

    localparam int DB = 16;
    localparam int ST = 64;
    localparam int SD = 8;

    logic clk = 1'b0;
    logic RST_n;
    logic PB_n;
    logic soft_req;
    logic soft_ack;
    logic rst_sens_n;
    logic rst_flt_n;
    logic rst_esc_n;
    logic rst_done;

    rst_sequencer #(
        .DB_CYCLES (DB),
        .STRETCH   (ST),
        .STAGE_DLY (SD)
    ) dut (
        .clk        (clk),
        .RST_n      (RST_n),
        .PB_n       (PB_n),
        .soft_req   (soft_req),
        .soft_ack   (soft_ack),
        .rst_sens_n (rst_sens_n),
        .rst_flt_n  (rst_flt_n),
        .rst_esc_n  (rst_esc_n),
        .rst_done   (rst_done)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int cyc      = 0;   // posedge index
    int rel      = 0;   // edges seen since RST_n went high
    int last_evt = 0;   // edge of the most recent reset event
    bit m_p0, m_p1;     // button as seen one and two edges ago
    bit m_deb;
    int m_run;          // consecutive samples disagreeing with m_deb
    bit m_req, m_arm, m_ack;

    function automatic void reset_model();
        m_p0 = 1'b1; m_p1 = 1'b1; m_deb = 1'b1; m_run = 0;
        m_req = 1'b0; m_arm = 1'b0; m_ack = 1'b0;
    endfunction

    function automatic logic [4:0] expv();
        int d;
        if (rel <= 2) return 5'b00000;
        d = cyc - last_evt;
        return {d >= ST, d >= ST + SD, d >= ST + 2*SD, d >= ST + 2*SD, m_ack};
    endfunction

    // Advance one clock edge and update the model from the inputs at that edge.
    task automatic step();
        bit sync, acc, ev;
        @(posedge clk);
        cyc++;
        if (!RST_n) begin
            rel = 0;
            reset_model();
        end else begin
            if (rel < 3) rel++;
            if (rel <= 2) begin
                reset_model();
                last_evt = cyc;
            end else begin
                sync = m_p1;
                acc  = m_req & m_arm;
                ev   = acc | !m_deb;
                if (sync != m_deb) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_deb = sync;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_p1 = m_p0;
                m_p0 = PB_n;
                if (!soft_req) m_arm = 1'b1;
                else if (acc)  m_arm = 1'b0;
                m_req = soft_req;
                m_ack = acc;
                if (ev) last_evt = cyc;
            end
        end
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {rst_sens_n, rst_flt_n, rst_esc_n, rst_done, soft_ack};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_n = 1'b0; PB_n = 1'b1; soft_req = 1'b0;
        repeat (5) begin
            step();
            vectors++;
            if (obs() !== expv() || obs() !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        RST_n = 1'b1;
        repeat (90) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL powerup cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_soft();
        soft_req = 1'b1;
        repeat (90) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL soft_held cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        soft_req = 1'b0;
        step();
        soft_req = 1'b1;
        repeat (90) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL soft_rearm cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        soft_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_soft_through_reset();
        soft_req = 1'b1;
        RST_n    = 1'b0;
        repeat (3) step();
        RST_n = 1'b1;
        repeat (90) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL soft_thru_rst cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        soft_req = 1'b0;
        step();
        soft_req = 1'b1;
        repeat (5) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL soft_after_low cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        soft_req = 1'b0;
        repeat (85) step();
    endtask

    task automatic test_bounce();
        int lo, hi;
        repeat (6) begin
            lo = $urandom_range(1, 12);
            hi = $urandom_range(1, 8);
            PB_n = 1'b0;
            repeat (lo) begin
                step();
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL bounce_low cyc=%0d got=%b exp=%b", cyc, obs(), expv());
                end
            end
            PB_n = 1'b1;
            repeat (hi) begin
                step();
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("FAIL bounce_high cyc=%0d got=%b exp=%b", cyc, obs(), expv());
                end
            end
        end
        repeat (20) step();
        PB_n = 1'b0;
        repeat (40) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL press_long cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        PB_n = 1'b1;
        repeat (150) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL press_release cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        bit reached = 1'b0;
        soft_req = 1'b0;
        step();
        soft_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (rel > 2 && (cyc - last_evt) == ST + SD + 3) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++;
        if (!reached || obs() !== expv()) begin
            miscompares++;
            $display("FAIL reach_flt cyc=%0d got=%b exp=%b reached=%0b", cyc, obs(), expv(), reached);
        end
        #2;
        RST_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== 5'b00000) begin
            miscompares++;
            $display("FAIL async_clear got=%b exp=00000", obs());
        end
        soft_req = 1'b0;
        repeat (3) step();
        RST_n = 1'b1;
        repeat (90) begin
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL async_recover cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_simultaneous();
        int acks = 0;
        // Debounced press lands on the 19th edge; soft accept on edge E+1,
        // so the request is first sampled high on the 18th edge.
        PB_n = 1'b0;
        soft_req = 1'b0;
        repeat (17) begin
            step();
            if (soft_ack === 1'b1) acks++;
        end
        soft_req = 1'b1;
        repeat (8) begin
            step();
            if (soft_ack === 1'b1) acks++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL simul_evt cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        PB_n = 1'b1;
        repeat (110) begin
            step();
            if (soft_ack === 1'b1) acks++;
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL simul_release cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        vectors++;
        if (acks !== 1) begin
            miscompares++;
            $display("FAIL simul_ack_count got=%0d exp=1", acks);
        end
        soft_req = 1'b0;
    endtask

    task automatic test_random();
        repeat (800) begin
            if ($urandom_range(0, 29) == 0) PB_n = ~PB_n;
            if ($urandom_range(0, 19) == 0) soft_req = ~soft_req;
            step();
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        PB_n = 1'b1;
        soft_req = 1'b0;
    endtask

    initial begin
        RST_n = 1'b0;
        PB_n = 1'b1;
        soft_req = 1'b0;
        reset_model();
        test_reset();
        test_soft();
        test_soft_through_reset();
        test_bounce();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
